timer_bank_sched: RTL

//  Time-multiplexed scheduler for a bank of NUM_TMR PLC timers (on-delay, off-delay, retentive).
//  One shared increment/compare datapath serves all slots, visited one per cycle after each timebase tick.
//  Per-slot type, preset and ACC are held in register arrays.

---
 rtl/timer_bank_sched.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/timer_bank_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// timer_bank_sched : time-multiplexed bank of on-delay/off-delay/retentive
// timers. Optional irq port/status enabled by TIMER_SCHED_IRQ_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module timer_bank_sched #(
    parameter int NUM_TMR  = 8,
    parameter int IDX_W    = 3,
    parameter int PRESET_W = 8,
    parameter int ACC_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [NUM_TMR-1:0]  en_vec,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic [1:0]          cmd_type,
    input  logic [PRESET_W-1:0] cmd_preset,
    output logic                rd_valid,
    output logic [ACC_W-1:0]    rd_acc,
    output logic                rd_dn,
    output logic                rd_tt,
    output logic [NUM_TMR-1:0]  dn_vec,
    output logic [NUM_TMR-1:0]  tt_vec,
    output logic                busy,
    output logic                overrun
`ifdef TIMER_SCHED_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [1:0] TYPE_ON  = 2'b00;
    localparam logic [1:0] TYPE_OFF = 2'b01;
    localparam logic [1:0] TYPE_RET = 2'b10;
    localparam logic [1:0] TYPE_DIS = 2'b11;
    localparam logic [1:0] OP_CFG   = 2'b00;
    localparam logic [1:0] OP_CLR   = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [1:0] OP_ACK   = 2'b11;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_TMR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CMD  = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    slot;
    logic                pend;
    logic [1:0]          tmr_type   [NUM_TMR];
    logic [PRESET_W-1:0] tmr_preset [NUM_TMR];
    logic [ACC_W-1:0]    tmr_acc    [NUM_TMR];

    logic                cmd_accept;
    logic                cur_en;
    logic                cur_dn;
    logic [ACC_W-1:0]    cur_acc;
    logic [ACC_W-1:0]    cur_pre;
    logic [ACC_W-1:0]    acc_inc;
    logic [ACC_W-1:0]    nxt_acc;
    logic                nxt_dn;
    logic                nxt_tt;

    assign cmd_ready  = (state == IDLE) & ~tick & ~pend;
    assign cmd_accept = cmd_valid & cmd_ready;
    assign busy       = (state == SCAN);
    assign overrun    = tick & pend;

    // Shared datapath: next ACC/DN/TT of the slot currently being scanned.
    // On the scan that reaches preset, TT still reports the increment and DN rises.
    always_comb begin
        cur_en  = en_vec[slot];
        cur_dn  = dn_vec[slot];
        cur_acc = tmr_acc[slot];
        cur_pre = ACC_W'(tmr_preset[slot]);
        acc_inc = cur_acc + ACC_W'(1);
        nxt_acc = cur_acc;
        nxt_dn  = 1'b0;
        nxt_tt  = 1'b0;
        case (tmr_type[slot])
            TYPE_ON, TYPE_RET: begin
                if (cur_en) begin
                    if (cur_acc < cur_pre) begin
                        nxt_acc = acc_inc;
                        nxt_tt  = 1'b1;
                        nxt_dn  = (acc_inc >= cur_pre);
                    end else begin
                        nxt_dn  = 1'b1;
                    end
                end else if (tmr_type[slot] == TYPE_ON) begin
                    nxt_acc = '0;
                end else begin
                    nxt_dn  = cur_dn;
                end
            end
            TYPE_OFF: begin
                if (cur_en) begin
                    nxt_acc = '0;
                    nxt_dn  = 1'b1;
                end else if (cur_dn && (cur_acc < cur_pre)) begin
                    nxt_acc = acc_inc;
                    nxt_tt  = 1'b1;
                    nxt_dn  = (acc_inc < cur_pre);
                end
            end
            TYPE_DIS: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            slot     <= '0;
            pend     <= 1'b0;
            rd_valid <= 1'b0;
            rd_acc   <= '0;
            rd_dn    <= 1'b0;
            rd_tt    <= 1'b0;
            dn_vec   <= '0;
            tt_vec   <= '0;
            for (int i = 0; i < NUM_TMR; i++) begin
                tmr_type[i]   <= TYPE_DIS;
                tmr_preset[i] <= '0;
                tmr_acc[i]    <= '0;
            end
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick || pend) begin
                        state <= SCAN;
                        slot  <= '0;
                        pend  <= 1'b0;
                    end else if (cmd_accept) begin
                        state <= CMD;
                        case (cmd_op)
                            OP_CFG: begin
                                tmr_type[cmd_idx]   <= cmd_type;
                                tmr_preset[cmd_idx] <= cmd_preset;
                                tmr_acc[cmd_idx]    <= '0;
                                dn_vec[cmd_idx]     <= 1'b0;
                                tt_vec[cmd_idx]     <= 1'b0;
                            end
                            OP_CLR: begin
                                tmr_acc[cmd_idx]    <= '0;
                                dn_vec[cmd_idx]     <= 1'b0;
                                tt_vec[cmd_idx]     <= 1'b0;
                            end
                            OP_RD: begin
                                rd_valid <= 1'b1;
                                rd_acc   <= tmr_acc[cmd_idx];
                                rd_dn    <= dn_vec[cmd_idx];
                                rd_tt    <= tt_vec[cmd_idx];
                            end
                            OP_ACK: ;
                            default: ;
                        endcase
                    end
                end
                SCAN: begin
                    tmr_acc[slot] <= nxt_acc;
                    dn_vec[slot]  <= nxt_dn;
                    tt_vec[slot]  <= nxt_tt;
                    pend          <= pend | tick;
                    if (slot == LAST_SLOT) begin
                        state <= IDLE;
                    end else begin
                        slot  <= slot + IDX_W'(1);
                    end
                end
                CMD: begin
                    state <= IDLE;
                    pend  <= pend | tick;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TIMER_SCHED_IRQ_EN
    logic [NUM_TMR-1:0] irq_stat;
    logic [NUM_TMR-1:0] irq_set;
    logic [NUM_TMR-1:0] irq_clr;

    always_comb begin
        irq_set = '0;
        irq_clr = '0;
        if ((state == SCAN) && nxt_dn && !cur_dn) begin
            irq_set[slot] = 1'b1;
        end
        if (cmd_accept && (cmd_op == OP_ACK)) begin
            irq_clr[cmd_idx] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a simultaneous set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_stat <= '0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
        end
    end

    assign irq = |irq_stat;
`endif

endmodule
`default_nettype wire
